config_uart_tx: RTL and testbench

- UART transmitter for the configuration port: the send-side counterpart of the config UART receiver.
- Accepts 32-bit words (readback data, status, or test stimulus for the receiver) over a strobe/ready handshake.
- Serializes each word as 4 bytes, 8N1, LSB-first within each byte, on a single Tx line.
- Sits beside the config UART receiver in the eFPGA configuration subsystem. Bench-side, it also drives the receiver's Rx input for loopback.

---
 rtl/config_uart_tx_pkg.sv | 23 ++
 rtl/config_uart_tx_if.sv | 10 +
 rtl/config_uart_tx_byte.sv | 89 ++++++++
 rtl/config_uart_tx.sv | 80 ++++++++
 tb/tb_config_uart_tx.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/config_uart_tx_pkg.sv
// Shared types and helpers for the config UART transmitter.
// CONFIG_UART_TX_PARITY_EN adds the PARITY state (8E1 framing).
package config_uart_tx_pkg;

    localparam int BITS_PER_BYTE  = 8;
    localparam int BYTES_PER_WORD = 4;

`ifdef CONFIG_UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} txState_e;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} txState_e;
`endif

    // Byte n in transmit order: n=0 goes out first.
    function automatic logic [7:0] selectByte(input logic [31:0] word,
                                              input logic [1:0]  n,
                                              input bit          msbFirst);
        logic [1:0] idx;
        idx = msbFirst ? (2'(BYTES_PER_WORD - 1) - n) : n;
        return word[idx*BITS_PER_BYTE +: BITS_PER_BYTE];
    endfunction

endpackage

// File: rtl/config_uart_tx_if.sv
// Word write handshake for the config UART transmitter: WriteStrobe/Ready.
// A word moves when WriteStrobe && Ready on a rising CLK edge.
interface config_uart_tx_if;
    logic [31:0] WriteData;
    logic        WriteStrobe;
    logic        Ready;

    modport master (output WriteData, output WriteStrobe, input Ready);
    modport slave  (input WriteData, input WriteStrobe, output Ready);
endinterface

// File: rtl/config_uart_tx_byte.sv
// Byte serializer: start, 8 data bits LSB-first, optional even parity
// (CONFIG_UART_TX_PARITY_EN), stop. Accepts a new byte in the last stop cycle.
module config_uart_tx_byte
    import config_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] byteIn,
    output logic       done,
    output logic       tx
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    txState_e         state, stateNext;
    logic [CNT_W-1:0] baudCnt, baudNext;
    logic [2:0]       bitCnt, bitCntNext;
    logic [7:0]       shiftByte;
    logic             txNext;
    logic             bitEnd;
    logic             loadByte;

    assign bitEnd   = (baudCnt == BAUD_LAST);
    assign done     = (state == STOP) && bitEnd;
    assign loadByte = (stateNext == START) && (state != START);

    always_comb begin
        stateNext  = state;
        baudNext   = baudCnt;
        bitCntNext = bitCnt;
        txNext     = 1'b1;

        case (state)
            IDLE:   if (start) stateNext = START;
            START:  if (bitEnd) stateNext = DATA;
            DATA: begin
                if (bitEnd && bitCnt == 3'(BITS_PER_BYTE - 1)) begin
`ifdef CONFIG_UART_TX_PARITY_EN
                    stateNext = PARITY;
`else
                    stateNext = STOP;
`endif
                end
            end
`ifdef CONFIG_UART_TX_PARITY_EN
            PARITY: if (bitEnd) stateNext = STOP;
`endif
            // A start in the final stop cycle chains the next byte with no gap.
            STOP:   if (bitEnd) stateNext = start ? START : IDLE;
            default: stateNext = IDLE;
        endcase

        if (state == IDLE || bitEnd) baudNext = '0;
        else                         baudNext = baudCnt + CNT_W'(1);

        if (state == START)              bitCntNext = 3'd0;
        else if (state == DATA && bitEnd) bitCntNext = bitCnt + 3'd1;

        case (stateNext)
            START:  txNext = 1'b0;
            DATA:   txNext = shiftByte[bitCntNext];
`ifdef CONFIG_UART_TX_PARITY_EN
            PARITY: txNext = ^shiftByte;
`endif
            default: txNext = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state     <= IDLE;
            baudCnt   <= '0;
            bitCnt    <= 3'd0;
            shiftByte <= 8'd0;
            tx        <= 1'b1;
        end else begin
            state   <= stateNext;
            baudCnt <= baudNext;
            bitCnt  <= bitCntNext;
            tx      <= txNext;
            if (loadByte) shiftByte <= byteIn;
        end
    end

endmodule

// File: rtl/config_uart_tx.sv
// Config-port UART transmitter: 32-bit word out as 4 bytes, Tx falls the edge after accept.
// Ready low for the whole word; strobes while busy are dropped. Parity via CONFIG_UART_TX_PARITY_EN.
module config_uart_tx
    import config_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT   = 217,
    parameter bit MSB_BYTE_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             reset,
    config_uart_tx_if.slave  bus,
    output logic             Tx,
    output logic             TxActive,
    output logic             TransmitLED
);

    localparam int BYTE_CNT_W = $clog2(BYTES_PER_WORD);
    localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(BYTES_PER_WORD - 1);

    logic [31:0]           wordBuf;
    logic [BYTE_CNT_W-1:0] byteCnt;
    logic                  readyQ;
    logic                  accept;
    logic                  byteDone;
    logic                  nextByteStart;
    logic                  wordDone;
    logic                  byteStart;
    logic [7:0]            byteData;
    logic                  txActiveNext;

    assign bus.Ready     = readyQ;
    assign accept        = bus.WriteStrobe && readyQ;
    assign nextByteStart = byteDone && (byteCnt != LAST_BYTE);
    assign wordDone      = byteDone && (byteCnt == LAST_BYTE);
    assign byteStart     = accept || nextByteStart;

    // The first byte bypasses wordBuf so Tx can fall on the accepting edge.
    always_comb begin
        byteData     = selectByte(wordBuf, byteCnt + BYTE_CNT_W'(1), MSB_BYTE_FIRST);
        txActiveNext = TxActive;
        if (accept) begin
            byteData     = selectByte(bus.WriteData, '0, MSB_BYTE_FIRST);
            txActiveNext = 1'b1;
        end else if (wordDone) begin
            txActiveNext = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            wordBuf     <= 32'd0;
            byteCnt     <= '0;
            TxActive    <= 1'b0;
            readyQ      <= 1'b0;
            TransmitLED <= 1'b0;
        end else begin
            if (accept) begin
                wordBuf <= bus.WriteData;
                byteCnt <= '0;
            end else if (nextByteStart) begin
                byteCnt <= byteCnt + BYTE_CNT_W'(1);
            end
            TxActive <= txActiveNext;
            readyQ   <= !txActiveNext;
            if (wordDone) TransmitLED <= !TransmitLED;
        end
    end

    config_uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte (
        .CLK    (CLK),
        .reset  (reset),
        .start  (byteStart),
        .byteIn (byteData),
        .done   (byteDone),
        .tx     (Tx)
    );

endmodule

// File: tb/tb_config_uart_tx.sv
// Bench for config_uart_tx: two instances (MSB-first and LSB-first byte order)
// driven in lockstep; Tx streams are logged per cycle and decoded by a UART receiver model.
module tb_config_uart_tx;

    localparam int CPB = 4;
`ifdef CONFIG_UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FB      = 10 + PAR;
    localparam int WORDLEN = 4 * FB * CPB;

    logic        CLK = 1'b0;
    logic        reset;
    logic        strobe;
    logic [31:0] wdata;
    logic        txA, txB, activeA, activeB, ledA, ledB;

    config_uart_tx_if busA ();
    config_uart_tx_if busB ();

    assign busA.WriteData   = wdata;
    assign busA.WriteStrobe = strobe;
    assign busB.WriteData   = wdata;
    assign busB.WriteStrobe = strobe;

    config_uart_tx #(.CLKS_PER_BIT(CPB), .MSB_BYTE_FIRST(1'b1)) dutA (
        .CLK(CLK), .reset(reset), .bus(busA),
        .Tx(txA), .TxActive(activeA), .TransmitLED(ledA)
    );

    config_uart_tx #(.CLKS_PER_BIT(CPB), .MSB_BYTE_FIRST(1'b0)) dutB (
        .CLK(CLK), .reset(reset), .bus(busB),
        .Tx(txB), .TxActive(activeB), .TransmitLED(ledB)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] word;
        logic [31:0] expA;   // byte stream in transmit order, MSB_BYTE_FIRST=1
        logic [31:0] expB;   // byte stream in transmit order, MSB_BYTE_FIRST=0
    } vec_t;

    vec_t vecs [3];

    int   nApplied = 0;
    int   nFail    = 0;
    logic txLogA  [0:511];
    logic txLogB  [0:511];
    logic actLog  [0:511];
    logic rdyLog  [0:511];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nApplied++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Log n cycles; WriteData changes after the accepting edge, strobe drops after cycle dropAt,
    // and an optional stray strobe pulse lands mid-word.
    task automatic capture(input int n, input int dropAt, input logic [31:0] newData, input bit pulse);
        for (int i = 1; i <= n; i++) begin
            tick();
            txLogA[i] = txA;
            txLogB[i] = txB;
            actLog[i] = activeA;
            rdyLog[i] = busA.Ready;
            if (i == 1)               wdata  = newData;
            if (i == dropAt)          strobe = 1'b0;
            if (pulse && i == 80)     strobe = 1'b1;
            if (pulse && i == 81)     strobe = 1'b0;
        end
    endtask

    function automatic logic sample(input bit fromB, input int idx);
        return fromB ? txLogB[idx] : txLogA[idx];
    endfunction

    // Receiver model: mid-bit sampling, start/stop framing and (if built) even parity.
    function automatic void decodeStream(input bit fromB, input int base,
                                         output logic [31:0] stream, output int errs);
        logic [7:0] b;
        int         p0;
        stream = '0;
        errs   = 0;
        for (int j = 0; j < 4; j++) begin
            p0 = base + j * FB * CPB;
            if (sample(fromB, p0 + CPB/2) !== 1'b0) errs++;
            for (int k = 0; k < 8; k++)
                b[k] = sample(fromB, p0 + (k + 1) * CPB + CPB/2);
            if (PAR != 0 && sample(fromB, p0 + 9 * CPB + CPB/2) !== ^b) errs++;
            if (sample(fromB, p0 + (FB - 1) * CPB + CPB/2) !== 1'b1) errs++;
            stream = {stream[23:0], b};
        end
    endfunction

    function automatic int countActive(input int n);
        int c = 0;
        for (int i = 1; i <= n; i++) if (actLog[i] === 1'b1) c++;
        return c;
    endfunction

    function automatic int firstReady(input int n);
        for (int i = 1; i <= n; i++) if (rdyLog[i] === 1'b1) return i;
        return -1;
    endfunction

    task automatic runWord(input logic [31:0] w, input logic [31:0] expA, input logic [31:0] expB);
        logic        ledBefore;
        logic [31:0] s;
        int          e;
        ledBefore = ledA;
        check("ready_before_word", {31'd0, busA.Ready}, 32'd1);
        wdata  = w;
        strobe = 1'b1;
        capture(WORDLEN + 2, 1, ~w, 1'b1);
        check("tx_falls_after_accept", {31'd0, txLogA[1]}, 32'd0);
        decodeStream(1'b0, 1, s, e);
        check("msb_first_bytes", s, expA);
        check("msb_first_framing_errs", e, 0);
        decodeStream(1'b1, 1, s, e);
        check("lsb_first_bytes", s, expB);
        check("lsb_first_framing_errs", e, 0);
        check("txactive_cycles", countActive(WORDLEN + 2), WORDLEN);
        check("ready_return_cycle", firstReady(WORDLEN + 2), WORDLEN + 1);
        check("led_toggled", {31'd0, ledA}, {31'd0, ~ledBefore});
    endtask

    initial begin
        logic [31:0] s;
        int          e;
        logic        ledBefore;

        vecs[0] = '{32'hA5C30F81, 32'hA5C30F81, 32'h810FC3A5};
        vecs[1] = '{32'h01030700, 32'h01030700, 32'h00070301};
        vecs[2] = '{32'h3C5AFF00, 32'h3C5AFF00, 32'h00FF5A3C};

        reset  = 1'b1;
        strobe = 1'b0;
        wdata  = 32'd0;
        tick();
        tick();
        check("reset_tx", {31'd0, txA}, 32'd1);
        check("reset_ready", {31'd0, busA.Ready}, 32'd0);
        check("reset_txactive", {31'd0, activeA}, 32'd0);
        check("reset_led", {31'd0, ledA}, 32'd0);
        reset = 1'b0;
        tick();
        check("ready_after_reset", {31'd0, busA.Ready}, 32'd1);
        check("tx_idle_after_reset", {31'd0, txA}, 32'd1);

        for (int v = 0; v < 3; v++)
            runWord(vecs[v].word, vecs[v].expA, vecs[v].expB);

        // Back-to-back with strobe held: second word takes the single Ready cycle.
        ledBefore = ledA;
        wdata  = 32'h00000000;
        strobe = 1'b1;
        capture(2 * WORDLEN + 3, WORDLEN + 2, 32'hFFFFFFFF, 1'b0);
        decodeStream(1'b0, 1, s, e);
        check("b2b_word1_bytes", s, 32'h00000000);
        check("b2b_word1_framing_errs", e, 0);
        decodeStream(1'b0, WORDLEN + 2, s, e);
        check("b2b_word2_bytes", s, 32'hFFFFFFFF);
        check("b2b_word2_framing_errs", e, 0);
        decodeStream(1'b1, WORDLEN + 2, s, e);
        check("b2b_word2_lsb_bytes", s, 32'hFFFFFFFF);
        check("b2b_ready_low_last_stop", {31'd0, rdyLog[WORDLEN]}, 32'd0);
        check("b2b_ready_gap", {31'd0, rdyLog[WORDLEN + 1]}, 32'd1);
        check("b2b_ready_taken", {31'd0, rdyLog[WORDLEN + 2]}, 32'd0);
        check("b2b_gap_tx_high", {31'd0, txLogA[WORDLEN + 1]}, 32'd1);
        check("b2b_word2_start", {31'd0, txLogA[WORDLEN + 2]}, 32'd0);
        check("b2b_active_cycles", countActive(2 * WORDLEN + 3), 2 * WORDLEN);
        check("b2b_led_toggled_twice", {31'd0, ledA}, {31'd0, ledBefore});

        // Reset in the middle of a word, then a clean word for the receiver model.
        wdata  = 32'h00000000;
        strobe = 1'b1;
        capture(50, 1, 32'h00000000, 1'b0);
        check("midword_tx_low_before_reset", {31'd0, txLogA[50]}, 32'd0);
        reset = 1'b1;
        tick();
        check("midword_reset_tx", {31'd0, txA}, 32'd1);
        check("midword_reset_tx_lsb", {31'd0, txB}, 32'd1);
        check("midword_reset_txactive", {31'd0, activeA}, 32'd0);
        check("midword_reset_ready", {31'd0, busA.Ready}, 32'd0);
        reset = 1'b0;
        tick();
        check("midword_ready_after_reset", {31'd0, busA.Ready}, 32'd1);
        runWord(32'h12345678, 32'h12345678, 32'h78563412);

        $display("== %0d vectors applied, %0d miscompares ==", nApplied, nFail);
        $finish;
    end

endmodule
